// File: rtl/piradip_axis_rr_arbiter_pkg.sv
// piradip_axis_arb_pkg: shared arbiter state type and rotating-priority pick helper.
package piradip_axis_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_PASS} arb_state_t;
  localparam int MAX_PORTS = 16;
  // Returns {found, idx}; scans from ptr upward, wrapping at n. Descending loop so the nearest offset wins.
  function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
    logic [4:0] r;
    logic [3:0] j;
    r = '0;
    for (int k = MAX_PORTS - 1; k >= 0; k--) begin
      j = 4'((int'(ptr) + k) % n);
      if (k < n && req[j]) r = {1'b1, j};
    end
    return r;
  endfunction
endpackage

// File: rtl/piradip_axis_rr_arbiter_if.sv
// piradip_axis_rr_arbiter_if: N source streams, one manager stream, mask and status of the arbiter.
interface piradip_axis_rr_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int WIDTH = 32,
  parameter int IDX_WIDTH = (N_PORTS > 1 ? $clog2(N_PORTS) : 1)
);
  logic [N_PORTS-1:0] s_tvalid;
  logic [N_PORTS-1:0] s_tready;
  logic [N_PORTS-1:0] s_tlast;
  logic [N_PORTS*WIDTH-1:0] s_tdata;
  logic [N_PORTS*WIDTH/8-1:0] s_tkeep;
  logic [N_PORTS-1:0] port_en;
  logic m_tvalid;
  logic m_tready;
  logic m_tlast;
  logic [WIDTH-1:0] m_tdata;
  logic [WIDTH/8-1:0] m_tkeep;
  logic [IDX_WIDTH-1:0] m_tid;
  logic busy;
  logic [IDX_WIDTH-1:0] grant_idx;
  modport master (
    input s_tvalid, s_tlast, s_tdata, s_tkeep, port_en, m_tready,
    output s_tready, m_tvalid, m_tlast, m_tdata, m_tkeep, m_tid, busy, grant_idx
  );
  modport slave (
    output s_tvalid, s_tlast, s_tdata, s_tkeep, port_en, m_tready,
    input s_tready, m_tvalid, m_tlast, m_tdata, m_tkeep, m_tid, busy, grant_idx
  );
endinterface

// File: rtl/piradip_rr_pick.sv
// piradip_rr_pick: combinational rotating-priority encoder, first request at or above ptr with wrap.
module piradip_rr_pick
  import piradip_axis_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_WIDTH = (N_PORTS > 1 ? $clog2(N_PORTS) : 1)
) (
  input  logic [N_PORTS-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 valid
);
  logic [4:0] r;
  assign r = rr_pick(16'(req), 4'(ptr), N_PORTS);
  assign idx = IDX_WIDTH'(r[3:0]);
  assign valid = r[4];
endmodule

// File: rtl/piradip_axis_rr_arbiter.sv
// piradip_axis_rr_arbiter: packet-level round-robin AXIS arbiter; grant held until tlast is accepted.
module piradip_axis_rr_arbiter
  import piradip_axis_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int WIDTH = 32,
  parameter int IDX_WIDTH = (N_PORTS > 1 ? $clog2(N_PORTS) : 1)
) (
  input logic aclk,
  input logic areset,
  piradip_axis_rr_arbiter_if.master bus
);
  arb_state_t state_q, state_d;
  logic [IDX_WIDTH-1:0] grant_q, grant_d, ptr_q, ptr_d, pick_idx;
  logic pick_valid, pass, fire_last;
  logic [WIDTH-1:0] dat [N_PORTS];
  logic [WIDTH/8-1:0] kp [N_PORTS];
  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign dat[i] = bus.s_tdata[i*WIDTH +: WIDTH];
    assign kp[i] = bus.s_tkeep[i*WIDTH/8 +: WIDTH/8];
  end
  piradip_rr_pick #(.N_PORTS(N_PORTS), .IDX_WIDTH(IDX_WIDTH)) u_pick (
    .req(bus.s_tvalid & bus.port_en),
    .ptr(ptr_q),
    .idx(pick_idx),
    .valid(pick_valid)
  );
  assign pass = state_q == ARB_PASS;
  assign bus.m_tvalid = pass & bus.s_tvalid[grant_q];
  assign bus.m_tlast = pass & bus.s_tlast[grant_q];
  assign bus.m_tdata = dat[grant_q];
  assign bus.m_tkeep = kp[grant_q];
  assign bus.m_tid = grant_q;
  assign bus.s_tready = pass ? N_PORTS'(bus.m_tready) << grant_q : '0;
  assign bus.busy = pass;
  assign bus.grant_idx = grant_q;
  assign fire_last = bus.m_tvalid & bus.m_tready & bus.m_tlast;
  always_comb begin
    state_d = pass ? (fire_last ? ARB_IDLE : ARB_PASS) : (pick_valid ? ARB_PASS : ARB_IDLE);
    grant_d = !pass && pick_valid ? pick_idx : grant_q;
    ptr_d = fire_last ? (grant_q == IDX_WIDTH'(N_PORTS - 1) ? '0 : grant_q + 1'b1) : ptr_q;
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: doc/piradip_axis_rr_arbiter.md
Name: piradip_axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI4-Stream manager port between N_PORTS subordinate stream sources.
- Grants one source at a time and holds the grant until that source's tlast beat is accepted downstream, so packets never interleave.
- Sits in front of shared stream consumers (DMA writers, framers) in the radio datapath.
- The source index is forwarded on m_tid so downstream logic can demultiplex.

Parameters:
- N_PORTS, 4, number of requesting streams (1..16).
- WIDTH, 32, tdata width in bits (multiple of 8).
- IDX_WIDTH, (N_PORTS>1 ? $clog2(N_PORTS) : 1), width of the grant index and m_tid.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- areset  in  1  asynchronous, active-high reset.
- s_tvalid  in  N_PORTS  per-source tvalid.
- s_tready  out  N_PORTS  per-source tready.
- s_tlast  in  N_PORTS  per-source tlast.
- s_tdata  in  N_PORTS*WIDTH  per-source tdata; source i occupies bits [i*WIDTH +: WIDTH].
- s_tkeep  in  N_PORTS*WIDTH/8  per-source tkeep; same packing as s_tdata.
- port_en  in  N_PORTS  arbitration enable mask; a disabled source is never newly granted.
- m_tvalid  out  1  output tvalid.
- m_tready  in  1  output tready.
- m_tlast  out  1  output tlast.
- m_tdata  out  WIDTH  output tdata.
- m_tkeep  out  WIDTH/8  output tkeep.
- m_tid  out  IDX_WIDTH  index of the granted source.
- busy  out  1  high while in state PASS.
- grant_idx  out  IDX_WIDTH  registered current/last grant.

Behaviour:
- Clock and reset: one clock, aclk. areset is asynchronous and active-high.
- Reset values: state=IDLE, grant_idx=0, rr_ptr=0, busy=0. All outputs derived from state, so s_tready=0, m_tvalid=0, m_tlast=0. m_tdata, m_tkeep and m_tid show source 0 (don't-care while m_tvalid=0).
- State IDLE:
  - req = s_tvalid & port_en.
  - If req is nonzero, select the first set bit scanning from rr_ptr upward, wrapping N_PORTS-1 to 0. On the next edge: grant_idx <= selected, state <= PASS.
  - All s_tready are 0 in IDLE.
  - This costs a one-cycle arbitration bubble per packet.
- State PASS (combinational pass-through, zero added latency):
  - m_tvalid = s_tvalid[grant_idx].
  - m_tdata, m_tkeep and m_tlast are taken from source grant_idx.
  - m_tid = grant_idx.
  - s_tready[grant_idx] = m_tready; every other s_tready is 0.
- Packet end: when m_tvalid & m_tready & m_tlast, on that edge state <= IDLE and rr_ptr <= (grant_idx==N_PORTS-1) ? 0 : grant_idx+1.
- Grant hold:
  - The grant persists across beats whose tvalid is low (source stall); there is no timeout.
  - Deasserting port_en for the granted source mid-packet does not revoke the grant. It takes effect only at the next arbitration.
- Single-beat packets (tlast on the first beat) take two cycles: IDLE then PASS.
- N_PORTS=1: rr_ptr stays 0; behaviour otherwise identical.
- Simultaneous requests are resolved purely by rotating priority. A source cannot win twice in a row while another enabled source is requesting.
- areset mid-packet returns the block immediately to IDLE with all readies low. The partial packet is abandoned; the arbiter does not generate tlast.
- A source asserting tvalid while not granted sees tready=0 and must hold its data (standard AXIS).

Decomposition:
- Package piradip_axis_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_PASS} arb_state_t;
  - function rr_pick(req, ptr), returning the index and a found bit.
- One sub-module: piradip_rr_pick. Combinational rotating-priority encoder, parameterized by N_PORTS; inputs req and ptr, outputs idx and valid. It is reused by future arbiters.
- The top level holds the state register, grant/rr_ptr registers, and the output mux.

Test Plan:
1. Reset and idle: after areset, all s_tvalid=0 for 10 cycles -> m_tvalid=0, s_tready=0000, busy=0, grant_idx=0.
2. Round-robin fairness: all 4 sources continuously offer 3-beat packets, m_tready=1 -> grant order 0,1,2,3,0,1. Each packet is 3 beats then a 1-cycle bubble; m_tid matches the source; no interleaving.
3. Wrap and skip: rr_ptr=3, only sources 1 and 2 valid -> source 1 granted, then source 2; rr_ptr ends at 3.
4. Backpressure and stall:
   - Source 2 sends 5 beats (data 0xA0..0xA4).
   - m_tready toggles 1010... and source 2 drops tvalid for 2 cycles mid-packet.
   - Required: output beats 0xA0..0xA4 in order with tlast on 0xA4 only.
   - s_tready[2] mirrors m_tready throughout; other sources' tready stays 0.
5. port_en mask: port_en=0b1011 with all sources valid -> source 2 is never granted. Clearing port_en[0] during source 0's packet lets that packet complete.
6. Reset mid-packet: assert areset asynchronously on beat 2 of a 4-beat packet -> m_tvalid and s_tready drop without waiting for a clock edge. After release, arbitration restarts from source 0.
